// File: rtl/xilinx_dist_fifo.sv
// Single-clock FIFO on distributed RAM with registered read data; optional sticky overflow/underflow via DIST_FIFO_STICKY_ERR_EN.
// Read latency 1 clock; writes are dropped while full and reads are dropped while empty, with no fall-through.
module xilinx_dist_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count
`ifdef DIST_FIFO_STICKY_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [WIDTH-1:0]      ram [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CW-1:0]         count_nxt;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count - CW'(1);
  end

  // Storage is never reset so it maps onto plain distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_acc)
      ram[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= ram[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      // Flags are computed from the next count so they move on the same edge.
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
    end
  end

`ifdef DIST_FIFO_STICKY_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)
        overflow <= 1'b1;
      if (rd_en && empty)
        underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_xilinx_dist_fifo.sv
// Bench for xilinx_dist_fifo: queue-based reference model compared every clock, plus directed literal checks.
module tb_xilinx_dist_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef DIST_FIFO_STICKY_ERR_EN
  logic       overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] exp_dout = 8'h00;
  logic       exp_dv = 1'b0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  xilinx_dist_fifo #(.WIDTH(8), .DEPTH_LOG2(4), .AFULL_LVL(14), .AEMPTY_LVL(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef DIST_FIFO_STICKY_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    q.delete();
    exp_dout = 8'h00;
    exp_dv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  end

  // Model advance and per-cycle comparison
  always @(posedge clk) begin
    if (rst_n) begin
      logic wa, ra;
      wa = wr_en && (q.size() != 16);
      ra = rd_en && (q.size() != 0);
      if (wr_en && q.size() == 16) exp_ovf = 1'b1;
      if (rd_en && q.size() == 0)  exp_unf = 1'b1;
      exp_dv = ra;
      if (ra) exp_dout = q.pop_front();
      if (wa) q.push_back(data_in);
      #1;
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == 16));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= 14));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
      chk("data_valid", 32'(data_valid), 32'(exp_dv));
      chk("data_out", 32'(data_out), 32'(exp_dout));
`ifdef DIST_FIFO_STICKY_ERR_EN
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_unf));
`endif
    end
  end

  // Drive one clock worth of requests; returns at the following negedge.
  task automatic cycle(input logic we, input logic [7:0] d, input logic re);
    wr_en   = we;
    data_in = d;
    rd_en   = re;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int maxcnt;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset mid-clock
    cycle(1'b1, 8'h33, 1'b0);
    async_reset();

    // 2: fill 16, then drain 16
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i + 1), 1'b0);
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
    end
    chk("fill_count_lit", 32'(count), 32'd16);
    chk("fill_full_lit", 32'(full), 32'd1);
    chk("fill_model", 32'(q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("drain_data_lit", 32'(data_out), 32'(i + 1));
      chk("drain_valid_lit", 32'(data_valid), 32'd1);
    end
    chk("drain_empty_lit", 32'(empty), 32'd1);

    // 3: 40 write/read pairs, wrapping the pointers twice
    maxcnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'hA0 + i), 1'b0);
      if (int'(count) > maxcnt) maxcnt = int'(count);
      cycle(1'b0, 8'h00, 1'b1);
      chk("wrap_data_lit", 32'(data_out), 32'(8'(8'hA0 + i)));
    end
    chk("wrap_max_count", 32'(maxcnt), 32'd1);

    // 4: simultaneous requests at full and at empty
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    chk("full_rw_data_lit", 32'(data_out), 32'h40);
    chk("full_rw_count_lit", 32'(count), 32'd15);
    chk("full_rw_full_lit", 32'(full), 32'd0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("drain_last_lit", 32'(data_out), 32'h4F);
    cycle(1'b1, 8'h77, 1'b1);
    chk("empty_rw_count_lit", 32'(count), 32'd1);
    chk("empty_rw_valid_lit", 32'(data_valid), 32'd0);
    chk("empty_rw_data_lit", 32'(data_out), 32'h4F);
    cycle(1'b0, 8'h00, 1'b1);
    chk("empty_rw_read_lit", 32'(data_out), 32'h77);

    // 5: ignored requests
    cycle(1'b0, 8'h00, 1'b1);
    chk("underflow_count_lit", 32'(count), 32'd0);
    chk("underflow_valid_lit", 32'(data_valid), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    chk("overflow_count_lit", 32'(count), 32'd16);
`ifdef DIST_FIFO_STICKY_ERR_EN
    chk("overflow_sticky_lit", 32'(overflow), 32'd1);
    chk("underflow_sticky_lit", 32'(underflow), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("overflow_order_lit", 32'(data_out), 32'(8'(8'hC0 + i)));
    end

    // Random traffic with phases biased towards filling and draining
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = ((i / 100) % 2 == 0) ? 75 : 25;
      cycle(($urandom_range(99) < bias), 8'($urandom), ($urandom_range(99) >= bias));
    end

    // 6: reset with 9 words queued
    async_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("pre_reset_count_lit", 32'(count), 32'd9);
    async_reset();
    chk("post_reset_count_lit", 32'(count), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("post_reset_blocked_lit", 32'(data_valid), 32'd0);
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("post_reset_data_lit", 32'(data_out), 32'h5A);
    chk("post_reset_valid_lit", 32'(data_valid), 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
